// File: rtl/regfile_pkg.sv
// Shared types and default sizing for the multi-port register file.
package regfile_pkg;
  typedef enum logic {RF_CLEAR = 1'b0, RF_RUN = 1'b1} rf_state_t;
  localparam int RF_DW = 32;
  localparam int RF_AW = 5;
  localparam int RF_NR = 2;
endpackage

// File: rtl/regfile_scoreboard.sv
// Per-register pending-write bits for issue-stage hazard detection.
// Optional REGFILE_BYPASS_EN masks pending on read ports hit by a same-cycle write.
module regfile_scoreboard
  import regfile_pkg::*;
#(
  parameter int AW = RF_AW,
  parameter int NR = RF_NR
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            i_busy,
  input  logic            i_clr0,
  input  logic [AW-1:0]   i_clr0_addr,
  input  logic            i_clr1,
  input  logic [AW-1:0]   i_clr1_addr,
  input  logic            i_set,
  input  logic [AW-1:0]   i_set_addr,
  input  logic [NR*AW-1:0] i_ra,
  output logic [NR-1:0]   o_rd_pend
);
  localparam int DEPTH = 1 << AW;

  logic [DEPTH-1:0] r_pend;

  // Set is applied last so it wins over a same-cycle clear of the same entry.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_pend <= '0;
    end else begin
      if (i_clr0) r_pend[i_clr0_addr] <= 1'b0;
      if (i_clr1) r_pend[i_clr1_addr] <= 1'b0;
      if (i_set)  r_pend[i_set_addr]  <= 1'b1;
    end
  end

  for (genvar i = 0; i < NR; i++) begin : g_port
    logic [AW-1:0] w_ra;
    logic          w_mask;
    assign w_ra = i_ra[i*AW +: AW];
`ifdef REGFILE_BYPASS_EN
    assign w_mask = ((i_clr0 && i_clr0_addr == w_ra) || (i_clr1 && i_clr1_addr == w_ra)) &&
                    !(i_set && i_set_addr == w_ra);
`else
    assign w_mask = 1'b0;
`endif
    assign o_rd_pend[i] = !i_busy && !w_mask && r_pend[w_ra];
  end
endmodule

// File: rtl/regfile_mp.sv
// Two-write, NR-read register file with post-reset clear sweep and pending scoreboard.
// Define REGFILE_BYPASS_EN to forward same-cycle write data to the read ports.
module regfile_mp
  import regfile_pkg::*;
#(
  parameter int DW       = RF_DW,
  parameter int AW       = RF_AW,
  parameter int NR       = RF_NR,
  parameter int ZERO_REG = 1
) (
  input  logic             clk,
  input  logic             rst,
  output logic             init_busy,
  input  logic             we0,
  input  logic [AW-1:0]    wa0,
  input  logic [DW-1:0]    wd0,
  input  logic             we1,
  input  logic [AW-1:0]    wa1,
  input  logic [DW-1:0]    wd1,
  input  logic [NR*AW-1:0] ra,
  output logic [NR*DW-1:0] rd,
  output logic [NR-1:0]    rd_pend,
  input  logic             sb_set,
  input  logic [AW-1:0]    sb_addr
);
  localparam int DEPTH = 1 << AW;

  rf_state_t     r_state, w_state_nxt;
  logic [AW-1:0] r_idx, w_idx_nxt;
  logic [DW-1:0] r_rf [DEPTH];
  logic          w_busy, w_acc0, w_acc1, w_sb_acc;

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= RF_CLEAR;
      r_idx   <= '0;
    end else begin
      r_state <= w_state_nxt;
      r_idx   <= w_idx_nxt;
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    w_idx_nxt   = r_idx;
    if (r_state == RF_CLEAR) begin
      w_idx_nxt = r_idx + 1'b1;
      if (r_idx == AW'(DEPTH - 1)) w_state_nxt = RF_RUN;
    end
  end

  assign w_busy    = (r_state == RF_CLEAR);
  assign init_busy = w_busy;

  // Writes and scoreboard sets are only accepted once the sweep is done.
  assign w_acc0   = we0 && !w_busy && !(ZERO_REG != 0 && wa0 == '0);
  assign w_acc1   = we1 && !w_busy && !(ZERO_REG != 0 && wa1 == '0);
  assign w_sb_acc = sb_set && !w_busy && !(ZERO_REG != 0 && sb_addr == '0);

  // Port 1 is written after port 0 so it wins on an address collision.
  always_ff @(posedge clk) begin
    if (!rst) begin
      if (r_state == RF_CLEAR) begin
        r_rf[r_idx] <= '0;
      end else begin
        if (w_acc0) r_rf[wa0] <= wd0;
        if (w_acc1) r_rf[wa1] <= wd1;
      end
    end
  end

  for (genvar i = 0; i < NR; i++) begin : g_rd
    logic [AW-1:0] w_ra;
    logic [DW-1:0] w_val;
    assign w_ra = ra[i*AW +: AW];
`ifdef REGFILE_BYPASS_EN
    assign w_val = (w_acc1 && wa1 == w_ra) ? wd1 :
                   (w_acc0 && wa0 == w_ra) ? wd0 : r_rf[w_ra];
`else
    assign w_val = r_rf[w_ra];
`endif
    assign rd[i*DW +: DW] = (w_busy || (ZERO_REG != 0 && w_ra == '0)) ? '0 : w_val;
  end

  regfile_scoreboard #(.AW(AW), .NR(NR)) u_sb (
    .clk         (clk),
    .rst         (rst),
    .i_busy      (w_busy),
    .i_clr0      (w_acc0),
    .i_clr0_addr (wa0),
    .i_clr1      (w_acc1),
    .i_clr1_addr (wa1),
    .i_set       (w_sb_acc),
    .i_set_addr  (sb_addr),
    .i_ra        (ra),
    .o_rd_pend   (rd_pend)
  );
endmodule
